// File: rtl/i2c_slave_byte_buffer.sv
// RX/TX byte FIFOs between the I2C slave datapath and user logic (clk1 domain).
// Optional macro I2C_BUF_LEVEL_EN exposes rx_level/tx_level occupancy outputs.
module i2c_slave_byte_buffer #(
  parameter int          DEPTH     = 8,
  parameter int          AW        = 3,
  parameter logic [7:0]  IDLE_BYTE = 8'hFF
) (
  input  logic         rst,
  input  logic         clk1,
  input  logic         flush,
  input  logic [7:0]   rx_byte,
  input  logic         rx_valid,
  input  logic         rx_pop,
  output logic [7:0]   rx_dout,
  output logic         rx_empty,
  output logic         rx_full,
  output logic         rx_overflow,
  input  logic         tx_push,
  input  logic [7:0]   tx_din,
  output logic         tx_empty,
  output logic         tx_full,
  output logic         tx_overflow,
  input  logic         tx_req,
  output logic [7:0]   tx_byte,
  output logic         tx_load,
  output logic         tx_underflow
`ifdef I2C_BUF_LEVEL_EN
  ,
  output logic [AW:0]  rx_level,
  output logic [AW:0]  tx_level
`endif
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0] rx_mem [DEPTH];
  logic [7:0] tx_mem [DEPTH];

  logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [AW:0]   rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [7:0]    rx_dout_q, rx_dout_d, tx_byte_q, tx_byte_d;
  logic          tx_load_q, tx_load_d;
  logic          rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d, tx_unf_q, tx_unf_d;
  logic          rx_valid_prev_q, rx_valid_prev_d;

  logic rx_push, rx_push_ok, rx_pop_ok, rx_we;
  logic tx_push_ok, tx_pop_ok, tx_we;

  always_comb begin
    rx_wr_ptr_d     = rx_wr_ptr_q;
    rx_rd_ptr_d     = rx_rd_ptr_q;
    rx_cnt_d        = rx_cnt_q;
    rx_dout_d       = rx_dout_q;
    rx_ovf_d        = rx_ovf_q;
    tx_wr_ptr_d     = tx_wr_ptr_q;
    tx_rd_ptr_d     = tx_rd_ptr_q;
    tx_cnt_d        = tx_cnt_q;
    tx_byte_d       = tx_byte_q;
    tx_load_d       = 1'b0;
    tx_ovf_d        = tx_ovf_q;
    tx_unf_d        = tx_unf_q;
    rx_valid_prev_d = rx_valid;
    rx_push         = rx_valid && !rx_valid_prev_q;
    rx_pop_ok       = 1'b0;
    rx_push_ok      = 1'b0;
    rx_we           = 1'b0;
    tx_pop_ok       = 1'b0;
    tx_push_ok      = 1'b0;
    tx_we           = 1'b0;

    if (flush) begin
      rx_wr_ptr_d = '0;
      rx_rd_ptr_d = '0;
      rx_cnt_d    = '0;
      rx_dout_d   = 8'h00;
      rx_ovf_d    = 1'b0;
      tx_wr_ptr_d = '0;
      tx_rd_ptr_d = '0;
      tx_cnt_d    = '0;
      tx_ovf_d    = 1'b0;
      tx_unf_d    = 1'b0;
    end else begin
      // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
      rx_pop_ok  = rx_pop && (rx_cnt_q != '0);
      rx_push_ok = rx_push && ((rx_cnt_q != FULL_CNT) || rx_pop_ok);
      rx_we      = rx_push_ok;
      if (rx_push && !rx_push_ok) rx_ovf_d = 1'b1;
      if (rx_pop_ok) rx_rd_ptr_d = rx_rd_ptr_q + 1'b1;
      if (rx_push_ok) rx_wr_ptr_d = rx_wr_ptr_q + 1'b1;
      if (rx_push_ok && !rx_pop_ok) rx_cnt_d = rx_cnt_q + 1'b1;
      else if (!rx_push_ok && rx_pop_ok) rx_cnt_d = rx_cnt_q - 1'b1;

      // Head register; bypass the incoming byte when it becomes the new head.
      if (rx_cnt_d == '0) rx_dout_d = 8'h00;
      else if (rx_push_ok && (rx_wr_ptr_q == rx_rd_ptr_d)) rx_dout_d = rx_byte;
      else rx_dout_d = rx_mem[rx_rd_ptr_d];

      tx_pop_ok  = tx_req && (tx_cnt_q != '0);
      tx_push_ok = tx_push && ((tx_cnt_q != FULL_CNT) || tx_pop_ok);
      tx_we      = tx_push_ok;
      if (tx_push && !tx_push_ok) tx_ovf_d = 1'b1;
      if (tx_pop_ok) tx_rd_ptr_d = tx_rd_ptr_q + 1'b1;
      if (tx_push_ok) tx_wr_ptr_d = tx_wr_ptr_q + 1'b1;
      if (tx_push_ok && !tx_pop_ok) tx_cnt_d = tx_cnt_q + 1'b1;
      else if (!tx_push_ok && tx_pop_ok) tx_cnt_d = tx_cnt_q - 1'b1;

      if (tx_req) begin
        tx_load_d = 1'b1;
        tx_byte_d = tx_pop_ok ? tx_mem[tx_rd_ptr_q] : IDLE_BYTE;
        if (!tx_pop_ok) tx_unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      rx_wr_ptr_q     <= '0;
      rx_rd_ptr_q     <= '0;
      rx_cnt_q        <= '0;
      rx_dout_q       <= 8'h00;
      rx_ovf_q        <= 1'b0;
      tx_wr_ptr_q     <= '0;
      tx_rd_ptr_q     <= '0;
      tx_cnt_q        <= '0;
      tx_byte_q       <= 8'h00;
      tx_load_q       <= 1'b0;
      tx_ovf_q        <= 1'b0;
      tx_unf_q        <= 1'b0;
      rx_valid_prev_q <= 1'b0;
    end else begin
      rx_wr_ptr_q     <= rx_wr_ptr_d;
      rx_rd_ptr_q     <= rx_rd_ptr_d;
      rx_cnt_q        <= rx_cnt_d;
      rx_dout_q       <= rx_dout_d;
      rx_ovf_q        <= rx_ovf_d;
      tx_wr_ptr_q     <= tx_wr_ptr_d;
      tx_rd_ptr_q     <= tx_rd_ptr_d;
      tx_cnt_q        <= tx_cnt_d;
      tx_byte_q       <= tx_byte_d;
      tx_load_q       <= tx_load_d;
      tx_ovf_q        <= tx_ovf_d;
      tx_unf_q        <= tx_unf_d;
      rx_valid_prev_q <= rx_valid_prev_d;
    end
  end

  // Storage is not reset; only pointers and counts define valid contents.
  always_ff @(posedge clk1) begin
    if (rx_we) rx_mem[rx_wr_ptr_q] <= rx_byte;
    if (tx_we) tx_mem[tx_wr_ptr_q] <= tx_din;
  end

  assign rx_dout      = rx_dout_q;
  assign rx_empty     = (rx_cnt_q == '0);
  assign rx_full      = (rx_cnt_q == FULL_CNT);
  assign rx_overflow  = rx_ovf_q;
  assign tx_empty     = (tx_cnt_q == '0);
  assign tx_full      = (tx_cnt_q == FULL_CNT);
  assign tx_overflow  = tx_ovf_q;
  assign tx_byte      = tx_byte_q;
  assign tx_load      = tx_load_q;
  assign tx_underflow = tx_unf_q;

`ifdef I2C_BUF_LEVEL_EN
  assign rx_level = rx_cnt_q;
  assign tx_level = tx_cnt_q;
`endif

endmodule

// File: tb/tb_i2c_slave_byte_buffer.sv
// Scoreboard bench for i2c_slave_byte_buffer: queue-based model, decoupled monitor.
module tb_i2c_slave_byte_buffer;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  localparam logic [7:0] IDLE = 8'hFF;

  logic rst, clk1, flush;
  logic [7:0] rx_byte, rx_dout, tx_din, tx_byte;
  logic rx_valid, rx_pop, rx_empty, rx_full, rx_overflow;
  logic tx_push, tx_empty, tx_full, tx_overflow, tx_req, tx_load, tx_underflow;
`ifdef I2C_BUF_LEVEL_EN
  logic [AW:0] rx_level, tx_level;
`endif

  i2c_slave_byte_buffer #(.DEPTH(DEPTH), .AW(AW), .IDLE_BYTE(IDLE)) dut (
    .rst(rst), .clk1(clk1), .flush(flush),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_pop(rx_pop), .rx_dout(rx_dout),
    .rx_empty(rx_empty), .rx_full(rx_full), .rx_overflow(rx_overflow),
    .tx_push(tx_push), .tx_din(tx_din), .tx_empty(tx_empty), .tx_full(tx_full),
    .tx_overflow(tx_overflow), .tx_req(tx_req), .tx_byte(tx_byte), .tx_load(tx_load),
    .tx_underflow(tx_underflow)
`ifdef I2C_BUF_LEVEL_EN
    , .rx_level(rx_level), .tx_level(tx_level)
`endif
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  int cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: plain queues plus flags.
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  bit m_rx_ovf, m_tx_ovf, m_tx_unf, m_prev;

  typedef struct { logic [7:0] b; int due; } tx_exp_t;
  logic [7:0] rx_exp_q[$];
  tx_exp_t    tx_exp_q[$];

  // Monitor: compares popped RX data and every TX load against the scoreboard.
  always @(negedge clk1) begin
    if (rst) begin
      if (rx_pop && rx_exp_q.size() > 0) begin
        chk("rx_pop_data", rx_dout, rx_exp_q.pop_front());
        $display("rx pop  cycle %0d data %02h", cyc, rx_dout);
      end
      if (tx_exp_q.size() > 0 && tx_exp_q[0].due == cyc) begin
        tx_exp_t e;
        e = tx_exp_q.pop_front();
        chk("tx_load", tx_load, 1);
        chk("tx_byte", tx_byte, e.b);
        $display("tx load cycle %0d byte %02h", cyc, tx_byte);
      end else if (tx_load) begin
        chk("tx_load_spurious", tx_load, 0);
      end
    end
  end

  task automatic check_state();
    chk("rx_empty", rx_empty, rxq.size() == 0);
    chk("rx_full", rx_full, rxq.size() == DEPTH);
    chk("rx_dout", rx_dout, (rxq.size() > 0) ? rxq[0] : 8'h00);
    chk("rx_overflow", rx_overflow, m_rx_ovf);
    chk("tx_empty", tx_empty, txq.size() == 0);
    chk("tx_full", tx_full, txq.size() == DEPTH);
    chk("tx_overflow", tx_overflow, m_tx_ovf);
    chk("tx_underflow", tx_underflow, m_tx_unf);
`ifdef I2C_BUF_LEVEL_EN
    chk("rx_level", rx_level, rxq.size());
    chk("tx_level", tx_level, txq.size());
`endif
  endtask

  task automatic model_reset();
    rxq.delete(); txq.delete(); rx_exp_q.delete(); tx_exp_q.delete();
    m_rx_ovf = 0; m_tx_ovf = 0; m_tx_unf = 0; m_prev = 0;
  endtask

  task automatic cycle(input logic v, input logic [7:0] b, input logic pop,
                       input logic push, input logic [7:0] din, input logic req,
                       input logic fl);
    check_state();
    rx_valid = v; rx_byte = b; rx_pop = pop; tx_push = push; tx_din = din;
    tx_req = req; flush = fl;
    if (fl) begin
      rxq.delete(); txq.delete();
      m_rx_ovf = 0; m_tx_ovf = 0; m_tx_unf = 0;
    end else begin
      if (pop && rxq.size() > 0) rx_exp_q.push_back(rxq.pop_front());
      if (v && !m_prev) begin
        if (rxq.size() < DEPTH) rxq.push_back(b);
        else m_rx_ovf = 1;
      end
      if (req) begin
        tx_exp_t e;
        e.due = cyc + 1;
        if (txq.size() > 0) e.b = txq.pop_front();
        else begin e.b = IDLE; m_tx_unf = 1; end
        tx_exp_q.push_back(e);
      end
      if (push) begin
        if (txq.size() < DEPTH) txq.push_back(din);
        else m_tx_ovf = 1;
      end
    end
    m_prev = v;
    @(posedge clk1); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    rx_valid = 0; rx_byte = 0; rx_pop = 0; tx_push = 0; tx_din = 0; tx_req = 0; flush = 0;
    #2;
    model_reset();
    check_state();
    chk("reset_tx_byte", tx_byte, 8'h00);
    chk("reset_tx_load", tx_load, 0);
    repeat (2) @(posedge clk1);
    #1 rst = 1'b1;
  endtask

  initial begin
    apply_reset();
    $display("reset released cycle %0d", cyc);

    // One push per rx_valid high period, then pop it back.
    for (int i = 0; i < 3; i++) cycle(1, 8'hA5, 0, 0, 8'h00, 0, 0);
    idle(2);
    chk("a5_head", rx_dout, 8'hA5);
    cycle(0, 8'h00, 1, 0, 8'h00, 0, 0);
    idle(1);

    // Nine edges into an eight-entry FIFO.
    for (int i = 1; i <= 9; i++) begin
      cycle(1, 8'(i), 0, 0, 8'h00, 0, 0);
      cycle(0, 8'(i), 0, 0, 8'h00, 0, 0);
    end
    chk("rx_full_after9", rx_full, 1);
    for (int i = 0; i < 9; i++) cycle(0, 8'h00, 1, 0, 8'h00, 0, 0);

    // TX: two bytes, two spaced requests.
    cycle(0, 8'h00, 0, 1, 8'h3C, 0, 0);
    cycle(0, 8'h00, 0, 1, 8'hC3, 0, 0);
    cycle(0, 8'h00, 0, 0, 8'h00, 1, 0);
    idle(2);
    cycle(0, 8'h00, 0, 0, 8'h00, 1, 0);
    idle(2);

    // Underflow: idle byte driven and flag held until flush.
    cycle(0, 8'h00, 0, 0, 8'h00, 1, 0);
    idle(3);
    cycle(0, 8'h00, 0, 0, 8'h00, 0, 1);
    idle(1);

    // Full RX with simultaneous pop and new edge.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, 8'h10 + 8'(i), 0, 0, 8'h00, 0, 0);
      cycle(0, 8'h00, 0, 0, 8'h00, 0, 0);
    end
    cycle(1, 8'h77, 1, 0, 8'h00, 0, 0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 1, 0, 8'h00, 0, 0);

    // Partly filled, flags set, flush with tx_req and rx_valid high.
    for (int i = 0; i < 9; i++) cycle(0, 8'h00, 0, 1, 8'(8'h40 + i), 0, 0);
    cycle(1, 8'h55, 0, 0, 8'h00, 0, 0);
    cycle(1, 8'h66, 0, 0, 8'h00, 1, 1);
    chk("flush_tx_load", tx_load, 0);
    cycle(1, 8'h66, 0, 0, 8'h00, 0, 0);
    idle(1);

    // Randomised traffic with occasional flush.
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 2) == 0), 8'($urandom), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 60) == 0));

    // Asynchronous reset mid-traffic.
    for (int i = 0; i < 5; i++) cycle(0, 8'h00, 0, 1, 8'(i), 0, 0);
    cycle(0, 8'h00, 0, 0, 8'h00, 1, 0);
    apply_reset();
    for (int i = 0; i < 200; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 4) == 0), 1'b0);
    idle(2);
    chk("tx_pending", tx_exp_q.size(), 0);
    chk("rx_pending", rx_exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_slave_byte_buffer.md
Name: i2c_slave_byte_buffer

Overview:
- Downstream/upstream companion of the I2C slave datapath, in the clk1 domain.
- Receive side captures each byte the slave datapath completes (data byte plus its level-type enable) into an RX FIFO for the user logic.
- Transmit side holds user-written bytes in a TX FIFO and presents one byte plus a one-cycle load strobe to the datapath's send-byte/send-enable inputs on each controller request.
- Sticky overflow/underflow flags and a synchronous flush.

Parameters:
- DEPTH, 8, entries per FIFO; must be a power of 2, minimum 2.
- AW, 3, pointer width, log2(DEPTH).
- IDLE_BYTE, 8'hFF, byte driven on underflow (released-bus level).

Ports:
- rst  input  1  asynchronous active-low reset.
- clk1  input  1  clock, same clock as slave datapath.
- flush  input  1  synchronous clear of both FIFOs and all sticky flags.
- rx_byte  input  8  received byte from slave datapath.
- rx_valid  input  1  receive-enable level from datapath; high from 8th bit until acknowledge.
- rx_pop  input  1  user pops RX head.
- rx_dout  output  8  RX head (first-word-fall-through).
- rx_empty  output  1  RX FIFO empty.
- rx_full  output  1  RX FIFO full.
- rx_overflow  output  1  sticky: byte dropped because RX full.
- tx_push  input  1  user writes tx_din.
- tx_din  input  8  byte to transmit.
- tx_empty  output  1  TX FIFO empty.
- tx_full  output  1  TX FIFO full.
- tx_overflow  output  1  sticky: push dropped because TX full.
- tx_req  input  1  single-cycle pulse from slave controller: next byte needed.
- tx_byte  output  8  byte to datapath send-data input.
- tx_load  output  1  one-cycle strobe to datapath send-enable input.
- tx_underflow  output  1  sticky: tx_req served while TX empty.

Behaviour:
- Reset (rst low, async): pointers and counts 0; rx_empty=1, tx_empty=1, rx_full=0, tx_full=0; rx_dout=8'h00; tx_byte=8'h00; tx_load=0; all sticky flags 0; edge-detect register 0. Memory contents not reset.
- Each FIFO: rd_ptr/wr_ptr AW bits, wrap modulo DEPTH; occupancy counter AW+1 bits, range 0..DEPTH. empty = count==0; full = count==DEPTH.
- RX push: on a 0->1 transition of rx_valid (registered previous value). One push per byte regardless of how long rx_valid stays high.
- RX write: if not full, write rx_byte at wr_ptr. If full, drop the byte and set rx_overflow.
- rx_pop: ignored when empty. rx_dout = mem[rd_ptr] when not empty, else 8'h00; it updates the cycle after a pop or the first push.
- RX simultaneous push and pop:
  - When full, pop frees the slot and the push is accepted; no overflow, count unchanged.
  - When empty, only the push takes effect; the pop is ignored.
- TX push: if not full, write tx_din. If full, drop and set tx_overflow. Simultaneous push and tx_req pop when full: both accepted.
- tx_req, TX not empty: on the next cycle tx_byte=head, tx_load=1 for exactly one cycle, rd_ptr advances. Latency 1 cycle.
- tx_req, TX empty: on the next cycle tx_byte=IDLE_BYTE, tx_load=1, tx_underflow set. A same-cycle tx_push is written but does not bypass to tx_byte.
- tx_byte holds its last value when tx_load=0.
- tx_req on consecutive cycles: each is served; back-to-back tx_load pulses.
- Sticky flags: set as above; cleared only by flush or reset.
- flush: highest priority. Same-cycle push/pop/req are discarded. Next cycle both FIFOs are empty, flags are 0, and tx_load=0. The rx_valid edge register still samples rx_valid, so a level already high does not re-push.
- Reset mid-transfer: immediate return to reset values; no partial byte retained.

Optional Feature:
- Macro I2C_BUF_LEVEL_EN.
- Defined: adds outputs rx_level and tx_level, each AW+1 bits, equal to the current occupancy counts (registered, reset 0, 0 after flush).
- Undefined: ports absent; counts internal only; all other behaviour identical.

Test Plan:
- Reset, then pulse rx_valid with rx_byte 8'hA5 held high 3 cycles -> exactly one push; rx_empty=0, rx_dout=8'hA5; rx_pop -> rx_empty=1, rx_dout=8'h00.
- 9 rx_valid rising edges with bytes 8'h01..8'h09, DEPTH=8 -> rx_full=1, rx_overflow=1, pops return 8'h01..8'h08 in order; 8'h09 lost.
- Push 8'h3C, 8'hC3 via tx_push; pulse tx_req twice, 3 cycles apart -> tx_load one-cycle pulses 1 cycle after each req, tx_byte 8'h3C then 8'hC3; tx_empty=1.
- tx_req with TX empty -> next cycle tx_load=1, tx_byte=8'hFF, tx_underflow=1; flag stays set until flush, then 0.
- RX full, rx_pop and new rx_valid edge (8'h77) same cycle -> count stays 8, no overflow; 8'h77 is the last byte popped.
- FIFOs partly filled, flags set, assert flush with tx_req high -> next cycle both empty, flags 0, tx_load=0; with I2C_BUF_LEVEL_EN, rx_level=tx_level=0.
